program_sequencer: RTL and testbench

//  Fetch/execute controller for the 4-bit processor: owns the program counter, drives the

---
 rtl/program_sequencer.sv | 98 +++++++++
 tb/tb_program_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Fetch/execute sequencer for the 4-bit processor: owns the PC, addresses the program ROM
// and issues one instruction per FETCH/EXEC slot, with SNZ skips and end-of-program handling.
module program_sequencer #(
    parameter int          ADDR_W      = 4,
    parameter int          END_ADDR    = 14,
    parameter bit          HALT_AT_END = 1'b1,
    parameter logic [3:0]  OP_SNZ_A    = 4'b1000,
    parameter logic [3:0]  OP_SNZ_S    = 4'b0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              flag_a_nz,
    input  logic              flag_s_nz,
    input  logic [3:0]        rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [3:0]        instr,
    output logic              exec_en,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [7:0]        retired
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [ADDR_W:0] END_X = (ADDR_W+1)'(END_ADDR);
    localparam logic [3:0]      NOP   = 4'b0111;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        instr_q, instr_d;
    logic [7:0]        retired_q, retired_d;
    logic              skip;
    logic [ADDR_W:0]   pc_inc;
    logic              past_end;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;

        skip = ((rom_data == OP_SNZ_A) && flag_a_nz) || ((rom_data == OP_SNZ_S) && flag_s_nz);
        // One extra bit keeps a step beyond END_ADDR visible even at the top of the address space.
        pc_inc   = {1'b0, pc_q} + (skip ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
        past_end = (pc_inc > END_X);

        case (state_q)
            S_IDLE: begin
                if (run || step) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                instr_d = rom_data;
                if (retired_q != 8'hFF) retired_d = retired_q + 8'd1;
                if (past_end && HALT_AT_END) begin
                    state_d = S_HALT;
                    pc_d    = ADDR_W'(END_ADDR);
                end else begin
                    state_d = run ? S_FETCH : S_IDLE;
                    if (past_end) pc_d = ADDR_W'(pc_inc - END_X - (ADDR_W+1)'(1));
                    else          pc_d = ADDR_W'(pc_inc);
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= NOP;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // The ROM answers for the current PC during EXEC, so instr passes it through there and
    // the register holds the last executed instruction in every other state.
    assign instr    = (state_q == S_EXEC) ? rom_data : instr_q;
    assign exec_en  = (state_q == S_EXEC);
    assign halted   = (state_q == S_HALT);
    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: two instances (halting END=14, wrapping END=7) with registered
// ROMs, directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_a = 1'b0, step_a = 1'b0, run_b = 1'b0, step_b = 1'b0;
    logic       fa = 1'b0, fs = 1'b0;
    logic [3:0] rd_a, rd_b;
    logic [3:0] addr_a, instr_a, pc_a, addr_b, instr_b, pc_b;
    logic       ex_a, halt_a, ex_b, halt_b;
    logic [7:0] ret_a, ret_b;

    int total = 0;
    int bad   = 0;

    logic [3:0] rom [2][16];
    int         m_pc [2];
    int         m_ret [2];
    bit         m_halt [2];
    logic [3:0] m_instr [2];
    bit         prev_ex [2];
    bit         seen [2][16];
    int         nexec [2];
    int         pcs [2][$];

    always #5 clk = ~clk;

    program_sequencer #(.ADDR_W(4), .END_ADDR(14), .HALT_AT_END(1'b1)) dut_a (
        .clk(clk), .rst(rst), .run(run_a), .step(step_a), .flag_a_nz(fa), .flag_s_nz(fs),
        .rom_data(rd_a), .rom_addr(addr_a), .instr(instr_a), .exec_en(ex_a), .pc(pc_a),
        .halted(halt_a), .retired(ret_a));

    program_sequencer #(.ADDR_W(4), .END_ADDR(7), .HALT_AT_END(1'b0)) dut_b (
        .clk(clk), .rst(rst), .run(run_b), .step(step_b), .flag_a_nz(fa), .flag_s_nz(fs),
        .rom_data(rd_b), .rom_addr(addr_b), .instr(instr_b), .exec_en(ex_b), .pc(pc_b),
        .halted(halt_b), .retired(ret_b));

    // Synchronous ROMs: data follows the address sampled at the previous edge.
    always @(posedge clk) begin
        rd_a <= rom[0][addr_a];
        rd_b <= rom[1][addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = 0; m_ret[d] = 0; m_halt[d] = 0; m_instr[d] = 4'b0111;
            prev_ex[d] = 0; nexec[d] = 0; pcs[d].delete();
            for (int i = 0; i < 16; i++) seen[d][i] = 0;
        end
    endtask

    // Instruction-level model: each executed instruction advances the PC by its own rules.
    task automatic mon(input int d, input logic [3:0] addr, input logic [3:0] ins, input logic ex,
                       input logic [3:0] pcv, input logic hl, input logic [7:0] rt);
        string p;
        int    ea, n;
        bit    hae, skp;
        logic [3:0] op;
        p   = (d == 0) ? "a." : "b.";
        ea  = (d == 0) ? 14 : 7;
        hae = (d == 0);
        chk({p, "pc"}, 32'(pcv), 32'(m_pc[d]));
        chk({p, "rom_addr"}, 32'(addr), 32'(m_pc[d]));
        chk({p, "retired"}, 32'(rt), 32'(m_ret[d]));
        chk({p, "halted"}, 32'(hl), 32'(m_halt[d]));
        chk({p, "exec_back_to_back"}, 32'(ex & prev_ex[d]), 32'd0);
        chk({p, "exec_while_halted"}, 32'(ex & hl), 32'd0);
        if (ex) begin
            op = rom[d][m_pc[d]];
            chk({p, "instr"}, 32'(ins), 32'(op));
            seen[d][m_pc[d]] = 1;
            pcs[d].push_back(m_pc[d]);
            nexec[d]++;
            m_instr[d] = op;
            skp = (op == 4'b1000 && fa) || (op == 4'b0100 && fs);
            n = m_pc[d] + (skp ? 2 : 1);
            if (n > ea) begin
                if (hae) begin m_halt[d] = 1; m_pc[d] = ea; end
                else m_pc[d] = n - ea - 1;
            end else m_pc[d] = n % 16;
            if (m_ret[d] < 255) m_ret[d]++;
        end else begin
            chk({p, "instr_hold"}, 32'(ins), 32'(m_instr[d]));
        end
        prev_ex[d] = ex;
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        else begin
            mon(0, addr_a, instr_a, ex_a, pc_a, halt_a, ret_a);
            mon(1, addr_b, instr_b, ex_b, pc_b, halt_b, ret_b);
        end
    end

    function automatic logic [3:0] plain_op();
        logic [3:0] v;
        do v = 4'($urandom_range(0, 15)); while (v == 4'b1000 || v == 4'b0100);
        return v;
    endfunction

    task automatic fill_plain();
        for (int i = 0; i < 16; i++) begin rom[0][i] = plain_op(); rom[1][i] = plain_op(); end
    endtask

    task automatic do_reset();
        rst = 1'b1; run_a = 0; run_b = 0; step_a = 0; step_b = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.pc", 32'(pc_a), 32'd0);
        chk("rst.exec_en", 32'(ex_a), 32'd0);
        chk("rst.instr", 32'(instr_a), 32'd7);
        chk("rst.retired", 32'(ret_a), 32'd0);
        chk("rst.halted", 32'(halt_a), 32'd0);
    endtask

    task automatic run_until_halt(input string tag, input int maxc);
        for (int i = 0; i < maxc && !halt_a; i++) begin @(negedge clk); #1; end
        chk({tag, ".halt_reached"}, 32'(halt_a), 32'd1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin rom[0][i] = 4'b0111; rom[1][i] = 4'b0111; end
        model_reset();

        // Free-run over ROM 0..14: exec_en every other cycle starting at cycle 2.
        for (int i = 0; i < 15; i++) rom[0][i] = 4'(i);
        rom[0][15] = 4'b0111;
        fa = 0; fs = 0;
        do_reset();
        run_a = 1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            chk($sformatf("t1.exec_cycle%0d", k), 32'(ex_a), 32'((k % 2 == 0) && k >= 2 && k <= 30));
        end
        chk("t1.retired", 32'(ret_a), 32'd15);
        chk("t1.halted", 32'(halt_a), 32'd1);
        chk("t1.pc", 32'(pc_a), 32'd14);

        // SNZ A at address 10, flag set then clear.
        fill_plain(); rom[0][10] = 4'b1000;
        do_reset(); fa = 1; run_a = 1;
        run_until_halt("t2a", 60);
        chk("t2a.retired", 32'(ret_a), 32'd14);
        chk("t2a.addr11_run", 32'(seen[0][11]), 32'd0);
        chk("t2a.addr12_run", 32'(seen[0][12]), 32'd1);
        do_reset(); fa = 0; run_a = 1;
        run_until_halt("t2b", 60);
        chk("t2b.retired", 32'(ret_a), 32'd15);
        chk("t2b.addr11_run", 32'(seen[0][11]), 32'd1);

        // SNZ S at address 13 skips past the end.
        fill_plain(); rom[0][13] = 4'b0100;
        do_reset(); fs = 1; run_a = 1;
        run_until_halt("t3", 60);
        chk("t3.retired", 32'(ret_a), 32'd14);
        chk("t3.addr14_run", 32'(seen[0][14]), 32'd0);
        chk("t3.pc", 32'(pc_a), 32'd14);
        fs = 0;

        // Single-step: pulses at cycles 0, 5, 10 plus one during the FETCH of cycle 6.
        fill_plain();
        do_reset();
        for (int c = 0; c < 18; c++) begin
            step_a = (c == 0 || c == 5 || c == 6 || c == 10);
            @(posedge clk); #1;
        end
        step_a = 0;
        @(negedge clk); #1;
        chk("t4.exec_count", 32'(nexec[0]), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t4.exec_pc%0d", i), (i < pcs[0].size()) ? 32'(pcs[0][i]) : 32'hFFFF, 32'(i));
        chk("t4.pc", 32'(pc_a), 32'd3);

        // Wrapping instance: 20 instructions, then run drops after the last EXEC.
        do_reset(); run_b = 1;
        for (int i = 0; i < 100 && nexec[1] < 20; i++) begin @(negedge clk); #1; end
        run_b = 0;
        repeat (6) @(negedge clk);
        #1;
        chk("t5.exec_count", 32'(nexec[1]), 32'd20);
        chk("t5.retired", 32'(ret_b), 32'd20);
        chk("t5.halted", 32'(halt_b), 32'd0);
        chk("t5.pc", 32'(pc_b), 32'd4);
        for (int i = 0; i < 20; i++)
            chk($sformatf("t5.exec_pc%0d", i), (i < pcs[1].size()) ? 32'(pcs[1][i]) : 32'hFFFF, 32'(i % 8));

        // Reset landing on the EXEC of address 5.
        do_reset(); run_a = 1;
        for (int i = 0; i < 40 && !(ex_a && pc_a == 4'd5); i++) @(negedge clk);
        chk("t6.reached_exec5", 32'(ex_a && pc_a == 4'd5), 32'd1);
        #1 rst = 1; run_a = 0;
        @(negedge clk);
        chk("t6.pc", 32'(pc_a), 32'd0);
        chk("t6.exec_en", 32'(ex_a), 32'd0);
        chk("t6.instr", 32'(instr_a), 32'd7);
        chk("t6.retired", 32'(ret_a), 32'd0);
        chk("t6.halted", 32'(halt_a), 32'd0);
        #1 rst = 0;
        repeat (3) begin @(negedge clk); chk("t6.idle", 32'(ex_a), 32'd0); end
        run_a = 1;
        @(negedge clk); chk("t6.fetch_after_idle", 32'(ex_a), 32'd0);
        @(negedge clk); chk("t6.exec_after_idle", 32'(ex_a), 32'd1);

        // Randomized traffic: any opcode, random flags, run levels and step pulses.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                rom[0][i] = 4'($urandom_range(0, 15));
                rom[1][i] = 4'($urandom_range(0, 15));
            end
            do_reset();
            for (int c = 0; c < 700; c++) begin
                @(posedge clk); #1;
                fa     = 1'($urandom_range(0, 1));
                fs     = 1'($urandom_range(0, 1));
                run_a  = ($urandom_range(0, 9) != 0);
                run_b  = ($urandom_range(0, 9) != 0);
                step_a = ($urandom_range(0, 5) == 0);
                step_b = ($urandom_range(0, 5) == 0);
            end
        end
        run_a = 0; run_b = 0; step_a = 0; step_b = 0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
